// File: rtl/video_frame_reader_if.sv
// Memory-side read port of the frame buffer: frame request handshake plus pixel FIFO pop.
interface video_frame_reader_if #(
    parameter int DATA_BITS = 16,
    parameter int ADDR_BITS = 25
) ();
    logic                 read_req;
    logic                 read_req_ack;
    logic                 read_finish;
    logic [1:0]           read_addr_index;
    logic [ADDR_BITS-1:0] read_len;
    logic                 read_en;
    logic [DATA_BITS-1:0] read_data;

    modport master (
        output read_req, read_addr_index, read_len, read_en,
        input  read_req_ack, read_finish, read_data
    );

    modport slave (
        input  read_req, read_addr_index, read_len, read_en,
        output read_req_ack, read_finish, read_data
    );
endinterface

// File: rtl/video_frame_reader.sv
// Display-side frame reader: requests the newest completed buffer once per frame, pops one
// pixel per active cycle and re-times hs/vs/de by one cycle to line up with the pixel data.
module video_frame_reader #(
    parameter int MEM_DATA_BITS = 64,
    parameter int DATA_BITS     = 16,
    parameter int ADDR_BITS     = 25,
    parameter int H_ACTIVE      = 1024,
    parameter int V_ACTIVE      = 768
) (
    input  logic                 read_clk,
    input  logic                 rst,
    input  logic                 vs_in,
    input  logic                 hs_in,
    input  logic                 de_in,
    input  logic [1:0]           frame_index,
    video_frame_reader_if.master mem,
    output logic                 vs_out,
    output logic                 hs_out,
    output logic                 de_out,
    output logic [DATA_BITS-1:0] pixel_out,
    output logic                 frame_skip,
    output logic                 frame_error
);
    localparam int TOTAL    = H_ACTIVE * V_ACTIVE;
    localparam int CNT_BITS = $clog2(TOTAL + 1);
    localparam logic [CNT_BITS-1:0]  TOTAL_C  = CNT_BITS'(TOTAL);
    localparam logic [ADDR_BITS-1:0] READ_LEN = ADDR_BITS'(TOTAL * DATA_BITS / MEM_DATA_BITS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_SKIP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                read_req_q, read_req_d;
    logic [1:0]          read_addr_index_q, read_addr_index_d;
    logic [CNT_BITS-1:0] pix_cnt_q, pix_cnt_d;
    logic                late_q, late_d;
    logic                vs_dly_q, vs_dly_d;
    logic                vs_out_q, vs_out_d;
    logic                hs_out_q, hs_out_d;
    logic                de_out_q, de_out_d;
    logic                valid_q, valid_d;
    logic                frame_skip_q, frame_skip_d;
    logic                frame_error_q, frame_error_d;

    logic                vs_rise_s;
    logic                start_s;
    logic                cnt_room_s;
    logic                read_en_s;
    logic                unused_read_finish_s;

    assign vs_rise_s  = vs_in & ~vs_dly_q;
    // A frame start is honoured everywhere except while a request is still outstanding.
    assign start_s    = vs_rise_s & (state_q != ST_REQ);
    assign cnt_room_s = (pix_cnt_q < TOTAL_C);
    assign unused_read_finish_s = mem.read_finish;

    // Next-state, frame bookkeeping and the combinational pop strobe.
    always_comb begin
        state_d           = state_q;
        read_req_d        = start_s ? 1'b1 : read_req_q;
        read_addr_index_d = start_s ? frame_index : read_addr_index_q;
        pix_cnt_d         = start_s ? {CNT_BITS{1'b0}} : pix_cnt_q;
        late_d            = start_s ? 1'b0 : late_q;
        frame_skip_d      = 1'b0;
        frame_error_d     = 1'b0;
        read_en_s         = 1'b0;
        vs_dly_d          = vs_in;
        vs_out_d          = vs_in;
        hs_out_d          = hs_in;
        de_out_d          = de_in;

        case (state_q)
            ST_IDLE: begin
                if (vs_rise_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Active video before the ack means this frame's data cannot be on time.
                late_d       = late_q | de_in;
                frame_skip_d = de_in & ~late_q;
                if (mem.read_req_ack) begin
                    read_req_d = 1'b0;
                    state_d    = (late_q | de_in) ? ST_SKIP : ST_ACTIVE;
                end else begin
                    read_req_d = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_ACTIVE: begin
                if (de_in && cnt_room_s) begin
                    read_en_s = 1'b1;
                    pix_cnt_d = start_s ? {CNT_BITS{1'b0}} : pix_cnt_q + CNT_BITS'(1);
                end else begin
                    frame_error_d = de_in;
                end
                if (vs_rise_s) begin
                    frame_error_d = frame_error_d | (pix_cnt_q != TOTAL_C);
                    state_d       = ST_REQ;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_SKIP: begin
                if (vs_rise_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_SKIP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                read_req_d = 1'b0;
            end
        endcase

        valid_d = read_en_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge read_clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            read_req_q        <= 1'b0;
            read_addr_index_q <= 2'd0;
            pix_cnt_q         <= {CNT_BITS{1'b0}};
            late_q            <= 1'b0;
            vs_dly_q          <= 1'b0;
            vs_out_q          <= 1'b0;
            hs_out_q          <= 1'b0;
            de_out_q          <= 1'b0;
            valid_q           <= 1'b0;
            frame_skip_q      <= 1'b0;
            frame_error_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            read_req_q        <= read_req_d;
            read_addr_index_q <= read_addr_index_d;
            pix_cnt_q         <= pix_cnt_d;
            late_q            <= late_d;
            vs_dly_q          <= vs_dly_d;
            vs_out_q          <= vs_out_d;
            hs_out_q          <= hs_out_d;
            de_out_q          <= de_out_d;
            valid_q           <= valid_d;
            frame_skip_q      <= frame_skip_d;
            frame_error_q     <= frame_error_d;
        end
    end

    assign mem.read_req        = read_req_q;
    assign mem.read_addr_index = read_addr_index_q;
    assign mem.read_len        = READ_LEN;
    assign mem.read_en         = read_en_s;

    assign vs_out      = vs_out_q;
    assign hs_out      = hs_out_q;
    assign de_out      = de_out_q;
    // Popped data arrives the cycle after read_en; blank it whenever no pop was issued.
    assign pixel_out   = valid_q ? mem.read_data : {DATA_BITS{1'b0}};
    assign frame_skip  = frame_skip_q;
    assign frame_error = frame_error_q;
endmodule
